// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD command driver: command codes, driver states and widths.
package lcd_pkg;

    localparam int unsigned CMD_W      = 4;
    localparam int unsigned ROM_AW     = 5;
    localparam int unsigned TMO_W      = 8;
    localparam int unsigned PIX_AW     = 6;
    localparam int unsigned PIX_DW     = 8;
    localparam int unsigned CNT_W      = 7;
    localparam int unsigned SUM_W      = 16;
    localparam int unsigned PIXELS_DEF = 64;

    localparam logic [CMD_W-1:0] CMD_WR  = 4'd0;
    localparam logic [CMD_W-1:0] CMD_SU  = 4'd1;
    localparam logic [CMD_W-1:0] CMD_SD  = 4'd2;
    localparam logic [CMD_W-1:0] CMD_SL  = 4'd3;
    localparam logic [CMD_W-1:0] CMD_SR  = 4'd4;
    localparam logic [CMD_W-1:0] CMD_MAX = 4'd5;
    localparam logic [CMD_W-1:0] CMD_MIN = 4'd6;
    localparam logic [CMD_W-1:0] CMD_AVG = 4'd7;
    localparam logic [CMD_W-1:0] CMD_CCW = 4'd8;
    localparam logic [CMD_W-1:0] CMD_CW  = 4'd9;
    localparam logic [CMD_W-1:0] CMD_MX  = 4'd10;
    localparam logic [CMD_W-1:0] CMD_MY  = 4'd11;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        LOAD,
        WAIT_RDY,
        ISSUE,
        WAIT_HI,
        WAIT_LO,
        WAIT_DONE,
        FIN,
        ERR
    } state_t;

    // Codes above MY are reserved and abort the program.
    function automatic logic cmd_illegal(input logic [CMD_W-1:0] code);
        return code >= 4'hC;
    endfunction

endpackage

// File: rtl/lcd_iram_monitor.sv
// Snoops the controller's IRAM write stream: write count, data checksum and address-order check.
module lcd_iram_monitor
    import lcd_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              IRAM_valid,
    input  logic [PIX_AW-1:0] IRAM_A,
    input  logic [PIX_DW-1:0] IRAM_D,
    output logic [CNT_W-1:0]  wr_count,
    output logic [SUM_W-1:0]  checksum,
    output logic              addr_err
);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic [PIX_AW-1:0] exp_q, exp_d;
    logic              err_q, err_d;

    // Clear has priority over a write landing in the same cycle.
    always_comb begin
        cnt_d = cnt_q;
        sum_d = sum_q;
        exp_d = exp_q;
        err_d = err_q;
        if (clr) begin
            cnt_d = '0;
            sum_d = '0;
            exp_d = '0;
            err_d = 1'b0;
        end else if (IRAM_valid) begin
            cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
            sum_d = sum_q + SUM_W'(IRAM_D);
            exp_d = exp_q + PIX_AW'(1);
            err_d = err_q | (IRAM_A != exp_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
            sum_q <= '0;
            exp_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sum_q <= sum_d;
            exp_q <= exp_d;
            err_q <= err_d;
        end
    end

    assign wr_count = cnt_q;
    assign checksum = sum_q;
    assign addr_err = err_q;

endmodule

// File: rtl/lcd_cmd_driver.sv
// Host-side sequencer: plays a command ROM program into the LCD controller and checks the frame it writes.
module lcd_cmd_driver
    import lcd_pkg::*;
#(
    parameter int unsigned CMD_DEPTH = 32,
    parameter int unsigned TIMEOUT   = 255,
    parameter int unsigned PIXELS    = PIXELS_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              CMDROM_rd,
    output logic [ROM_AW-1:0] CMDROM_A,
    input  logic [CMD_W-1:0]  CMDROM_Q,
    output logic [CMD_W-1:0]  cmd,
    output logic              cmd_valid,
    input  logic              busy,
    input  logic              done,
    input  logic              IRAM_valid,
    input  logic [PIX_AW-1:0] IRAM_A,
    input  logic [PIX_DW-1:0] IRAM_D,
    output logic              seq_done,
    output logic              pass,
    output logic              error,
    output logic [CNT_W-1:0]  wr_count,
    output logic [SUM_W-1:0]  checksum
);

    state_t            state_q, state_d;
    logic [ROM_AW-1:0] ptr_q, ptr_d;
    logic [ROM_AW-1:0] addr_q, addr_d;
    logic [CMD_W-1:0]  cmd_q, cmd_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              rd_q, rd_d;
    logic              cv_q, cv_d;
    logic              seq_done_q, seq_done_d;
    logic              pass_q, pass_d;
    logic              error_q, error_d;
    logic              mon_clr;
    logic              addr_err;
    logic              tmo_hit;

    assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT));

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cmd_d      = cmd_q;
        seq_done_d = seq_done_q;
        pass_d     = pass_q;
        error_d    = error_q;
        mon_clr    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    ptr_d      = '0;
                    seq_done_d = 1'b0;
                    pass_d     = 1'b0;
                    error_d    = 1'b0;
                    mon_clr    = 1'b1;
                    state_d    = FETCH;
                end
            end
            FETCH: state_d = LOAD;
            LOAD: begin
                cmd_d   = CMDROM_Q;
                state_d = cmd_illegal(CMDROM_Q) ? ERR : WAIT_RDY;
            end
            WAIT_RDY: begin
                if (!busy)        state_d = ISSUE;
                else if (tmo_hit) state_d = ERR;
            end
            ISSUE: state_d = (cmd_q == CMD_WR) ? WAIT_DONE : WAIT_HI;
            WAIT_HI: begin
                if (busy)         state_d = WAIT_LO;
                else if (tmo_hit) state_d = ERR;
            end
            WAIT_LO: begin
                // Running off the end of the ROM without a write is a program error.
                if (!busy) begin
                    if (ptr_q == ROM_AW'(CMD_DEPTH - 1)) begin
                        state_d = ERR;
                    end else begin
                        ptr_d   = ptr_q + ROM_AW'(1);
                        state_d = FETCH;
                    end
                end else if (tmo_hit) begin
                    state_d = ERR;
                end
            end
            WAIT_DONE: begin
                if (done)         state_d = FIN;
                else if (tmo_hit) state_d = ERR;
            end
            FIN: begin
                seq_done_d = 1'b1;
                pass_d     = (wr_count == CNT_W'(PIXELS)) && !addr_err;
                state_d    = IDLE;
            end
            ERR: begin
                error_d    = 1'b1;
                seq_done_d = 1'b1;
                pass_d     = 1'b0;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered strobes are decoded from the upcoming state so they line up with it.
    always_comb begin
        rd_d   = (state_d == FETCH);
        cv_d   = (state_d == ISSUE);
        addr_d = (state_d == FETCH) ? ptr_d : addr_q;
        tmo_d  = (state_d != state_q) ? '0 : tmo_q + TMO_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            addr_q     <= '0;
            cmd_q      <= '0;
            tmo_q      <= '0;
            rd_q       <= 1'b0;
            cv_q       <= 1'b0;
            seq_done_q <= 1'b0;
            pass_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            addr_q     <= addr_d;
            cmd_q      <= cmd_d;
            tmo_q      <= tmo_d;
            rd_q       <= rd_d;
            cv_q       <= cv_d;
            seq_done_q <= seq_done_d;
            pass_q     <= pass_d;
            error_q    <= error_d;
        end
    end

    lcd_iram_monitor u_mon (
        .clk        (clk),
        .reset      (reset),
        .clr        (mon_clr),
        .IRAM_valid (IRAM_valid),
        .IRAM_A     (IRAM_A),
        .IRAM_D     (IRAM_D),
        .wr_count   (wr_count),
        .checksum   (checksum),
        .addr_err   (addr_err)
    );

    assign CMDROM_rd = rd_q;
    assign CMDROM_A  = addr_q;
    assign cmd       = cmd_q;
    assign cmd_valid = cv_q;
    assign seq_done  = seq_done_q;
    assign pass      = pass_q;
    assign error     = error_q;

endmodule

// File: tb/tb_lcd_cmd_driver.sv
// Directed bench for lcd_cmd_driver with a command ROM and a behavioural LCD controller.
module tb_lcd_cmd_driver;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        CMDROM_rd;
    logic [4:0]  CMDROM_A;
    logic [3:0]  CMDROM_Q;
    logic [3:0]  cmd;
    logic        cmd_valid;
    logic        busy;
    logic        done = 1'b0;
    logic        IRAM_valid = 1'b0;
    logic [5:0]  IRAM_A = 6'd0;
    logic [7:0]  IRAM_D = 8'd0;
    logic        seq_done;
    logic        pass;
    logic        error;
    logic [6:0]  wr_count;
    logic [15:0] checksum;

    logic        busy_m = 1'b0;
    logic        busy_force = 1'b0;
    logic [3:0]  rom [32];
    logic [5:0]  addr_tab [64];
    logic [3:0]  cmd_log [256];
    int          issue_cnt = 0;
    int          viol = 0;
    int          checks = 0;
    int          errors = 0;

    assign busy = busy_m | busy_force;

    always #5 clk = ~clk;

    lcd_cmd_driver dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .CMDROM_rd  (CMDROM_rd),
        .CMDROM_A   (CMDROM_A),
        .CMDROM_Q   (CMDROM_Q),
        .cmd        (cmd),
        .cmd_valid  (cmd_valid),
        .busy       (busy),
        .done       (done),
        .IRAM_valid (IRAM_valid),
        .IRAM_A     (IRAM_A),
        .IRAM_D     (IRAM_D),
        .seq_done   (seq_done),
        .pass       (pass),
        .error      (error),
        .wr_count   (wr_count),
        .checksum   (checksum)
    );

    // Synchronous command ROM: data one cycle after the read strobe.
    always @(posedge clk) begin
        if (CMDROM_rd) CMDROM_Q <= rom[CMDROM_A];
    end

    // Controller model: busy 2 cycles after a command; WR streams addr_tab then pulses done.
    always begin
        logic [3:0] cur;
        @(negedge clk);
        if (cmd_valid) begin
            cur = cmd;
            cmd_log[8'(issue_cnt)] = cur;
            issue_cnt = issue_cnt + 1;
            repeat (2) @(negedge clk);
            busy_m = 1'b1;
            if (cur == 4'd0) begin
                for (int i = 0; i < 64; i++) begin
                    IRAM_valid = 1'b1;
                    IRAM_A     = addr_tab[i];
                    IRAM_D     = 8'(addr_tab[i]);
                    @(negedge clk);
                end
                IRAM_valid = 1'b0;
                busy_m     = 1'b0;
                done       = 1'b1;
                @(negedge clk);
                done       = 1'b0;
            end else begin
                repeat (3) @(negedge clk);
                busy_m = 1'b0;
            end
        end
    end

    // Handshake rule watcher: no strobe while busy, never two in a row.
    always @(negedge clk) begin
        logic cv_prev;
        if (cmd_valid && (cv_prev === 1'b1 || busy)) viol = viol + 1;
        cv_prev = cmd_valid;
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_seq(input int budget, input string name);
        int k = 0;
        while (!seq_done && k < budget) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (seq_done !== 1'b1) begin
            errors++;
            $display("FAIL %s_wait: seq_done=%b after %0d cycles, required 1", name, seq_done, k);
        end
    endtask

    task automatic load_prog(input logic [3:0] c0, input logic [3:0] c1, input logic [3:0] c2, input logic [3:0] fill);
        for (int i = 0; i < 32; i++) rom[i] = fill;
        rom[0] = c0;
        rom[1] = c1;
        rom[2] = c2;
        for (int i = 0; i < 64; i++) addr_tab[i] = 6'(i);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({CMDROM_rd, CMDROM_A, cmd, cmd_valid, seq_done, pass, error} !== 14'd0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, required 0", {CMDROM_rd, CMDROM_A, cmd, cmd_valid, seq_done, pass, error});
        end
        checks++;
        if ({wr_count, checksum} !== 23'd0) begin
            errors++;
            $display("FAIL reset_mon: wr_count=%0d checksum=%0d, required 0 0", wr_count, checksum);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_normal();
        int base;
        load_prog(4'd4, 4'd5, 4'd0, 4'd0);
        base = issue_cnt;
        pulse_start();
        wait_seq(600, "normal");
        checks++;
        if (issue_cnt - base !== 3) begin
            errors++;
            $display("FAIL normal_issues: got %0d, required 3", issue_cnt - base);
        end
        checks++;
        if ({cmd_log[8'(base)], cmd_log[8'(base + 1)], cmd_log[8'(base + 2)]} !== 12'h450) begin
            errors++;
            $display("FAIL normal_cmds: got %h %h %h, required 4 5 0",
                     cmd_log[8'(base)], cmd_log[8'(base + 1)], cmd_log[8'(base + 2)]);
        end
        checks++;
        if (pass !== 1'b1 || error !== 1'b0) begin
            errors++;
            $display("FAIL normal_pass: pass=%b error=%b, required 1 0", pass, error);
        end
        checks++;
        if (wr_count !== 7'd64 || checksum !== 16'd2016) begin
            errors++;
            $display("FAIL normal_mon: wr_count=%0d checksum=%0d, required 64 2016", wr_count, checksum);
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_busy_timeout();
        int base;
        load_prog(4'd4, 4'd5, 4'd0, 4'd0);
        busy_force = 1'b1;
        base = issue_cnt;
        pulse_start();
        wait_seq(400, "timeout");
        checks++;
        if (error !== 1'b1 || pass !== 1'b0 || seq_done !== 1'b1) begin
            errors++;
            $display("FAIL timeout_flags: error=%b pass=%b seq_done=%b, required 1 0 1", error, pass, seq_done);
        end
        checks++;
        if (issue_cnt - base !== 0) begin
            errors++;
            $display("FAIL timeout_issues: got %0d, required 0", issue_cnt - base);
        end
        checks++;
        if (wr_count !== 7'd0 || checksum !== 16'd0) begin
            errors++;
            $display("FAIL timeout_mon_clr: wr_count=%0d checksum=%0d, required 0 0", wr_count, checksum);
        end
        busy_force = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_illegal_code();
        int base;
        load_prog(4'd4, 4'hD, 4'd0, 4'd0);
        base = issue_cnt;
        pulse_start();
        checks++;
        if (error !== 1'b0 || seq_done !== 1'b0) begin
            errors++;
            $display("FAIL illegal_start_clr: error=%b seq_done=%b, required 0 0", error, seq_done);
        end
        wait_seq(200, "illegal");
        checks++;
        if (issue_cnt - base !== 1 || cmd_log[8'(base)] !== 4'd4) begin
            errors++;
            $display("FAIL illegal_issues: count=%0d first=%h, required 1 4", issue_cnt - base, cmd_log[8'(base)]);
        end
        checks++;
        if (error !== 1'b1 || pass !== 1'b0 || cmd !== 4'hD) begin
            errors++;
            $display("FAIL illegal_err: error=%b pass=%b cmd=%h, required 1 0 d", error, pass, cmd);
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_addr_order();
        load_prog(4'd4, 4'd5, 4'd0, 4'd0);
        addr_tab[32] = 6'd33;
        addr_tab[33] = 6'd32;
        pulse_start();
        wait_seq(600, "addr");
        checks++;
        if (wr_count !== 7'd64 || checksum !== 16'd2016) begin
            errors++;
            $display("FAIL addr_mon: wr_count=%0d checksum=%0d, required 64 2016", wr_count, checksum);
        end
        checks++;
        if (pass !== 1'b0 || error !== 1'b0) begin
            errors++;
            $display("FAIL addr_pass: pass=%b error=%b, required 0 0", pass, error);
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_no_write();
        int base;
        load_prog(4'd1, 4'd1, 4'd1, 4'd1);
        base = issue_cnt;
        pulse_start();
        wait_seq(1500, "nowrite");
        checks++;
        if (issue_cnt - base !== 32) begin
            errors++;
            $display("FAIL nowrite_issues: got %0d, required 32", issue_cnt - base);
        end
        checks++;
        if (error !== 1'b1 || pass !== 1'b0) begin
            errors++;
            $display("FAIL nowrite_err: error=%b pass=%b, required 1 0", error, pass);
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int base;
        int k = 0;
        load_prog(4'd4, 4'd5, 4'd0, 4'd0);
        base = issue_cnt;
        pulse_start();
        while (!busy_m && k < 50) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (busy_m !== 1'b1) begin
            errors++;
            $display("FAIL midrst_busy_wait: busy=%b after %0d cycles, required 1", busy_m, k);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({CMDROM_rd, CMDROM_A, cmd, cmd_valid, seq_done, pass, error, wr_count, checksum} !== 37'd0) begin
            errors++;
            $display("FAIL midrst_outputs: cmd=%h rd=%b A=%0d cv=%b sd=%b pass=%b err=%b, required all 0",
                     cmd, CMDROM_rd, CMDROM_A, cmd_valid, seq_done, pass, error);
        end
        reset = 1'b1;
        repeat (15) @(negedge clk);
        checks++;
        if (issue_cnt - base !== 1) begin
            errors++;
            $display("FAIL midrst_abort: issues=%0d, required 1", issue_cnt - base);
        end
        pulse_start();
        checks++;
        if (CMDROM_rd !== 1'b1 || CMDROM_A !== 5'd0) begin
            errors++;
            $display("FAIL midrst_restart: rd=%b A=%0d, required 1 0", CMDROM_rd, CMDROM_A);
        end
        wait_seq(600, "midrst");
        checks++;
        if (pass !== 1'b1 || wr_count !== 7'd64) begin
            errors++;
            $display("FAIL midrst_rerun: pass=%b wr_count=%0d, required 1 64", pass, wr_count);
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic test_handshake_rules();
        checks++;
        if (viol !== 0) begin
            errors++;
            $display("FAIL handshake_rules: violations=%0d, required 0", viol);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = 4'd0;
        for (int i = 0; i < 64; i++) addr_tab[i] = 6'(i);
        for (int i = 0; i < 256; i++) cmd_log[i] = 4'd0;
        test_reset();
        test_normal();
        test_busy_timeout();
        test_illegal_code();
        test_addr_order();
        test_no_write();
        test_reset_mid();
        test_handshake_rules();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
